// File: rtl/imem_loader_if.sv
// Byte-stream handshake bundle feeding the instruction-memory loader.
// The master side (host/debug source) drives valid and data; the slave
// side (the loader) drives ready.
interface imem_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs an incoming byte stream into little-endian 32-bit
// instruction words and writes them to the IMEM at consecutive word
// addresses (wrapping modulo DEPTH). The CPU is held in reset until a load
// completes.
//
// Optional build macro IMEM_LOADER_CSUM_EN: when defined, csum accumulates
// the sum of all written words (mod 2^32); otherwise csum is tied to zero.
module imem_loader #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_word,
  input  logic [ADDR_W:0]   len_words,
  imem_loader_if.slave      byte_in,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [31:0]       csum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_inc;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] base;
  logic [23:0]       word_buf;
  logic              s_ready;
  logic              start_ok;
  logic              xfer;
  logic              last_byte;

  assign byte_in.s_ready = s_ready;

  // Handshake qualifiers: start is honoured only when idle or finished,
  // and a byte moves only while loading.
  always_comb begin
    start_ok     = start && ((state == IDLE) || (state == DONE));
    xfer         = byte_in.s_valid && (state == LOAD);
    last_byte    = xfer && (byte_cnt == 2'd3);
    word_cnt_inc = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
  end

  // Next-state decode for the load sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          if (len_words == {(ADDR_W+1){1'b0}}) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
          end
        end else begin
          state_next = state;
        end
      end
      LOAD: begin
        if (last_byte) begin
          state_next = WRITE;
        end else begin
          state_next = LOAD;
        end
      end
      WRITE: begin
        if (word_cnt_inc == len) begin
          state_next = DONE;
        end else begin
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status/handshake outputs registered from the next state so they line
  // up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready  <= 1'b0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      s_ready  <= (state_next == LOAD);
      we       <= (state_next == WRITE);
      busy     <= (state_next == LOAD) || (state_next == WRITE);
      done     <= (state_next == DONE);
      cpu_hold <= (state_next != DONE);
    end
  end

  // Datapath: latch the job, pack bytes little-endian, and register the
  // IMEM address/data when the fourth byte of a word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= {ADDR_W{1'b0}};
      len      <= {(ADDR_W+1){1'b0}};
      byte_cnt <= 2'd0;
      word_cnt <= {(ADDR_W+1){1'b0}};
      word_buf <= 24'h000000;
      waddr    <= {ADDR_W{1'b0}};
      wdata    <= 32'h0000_0000;
    end else if (start_ok) begin
      base     <= base_word;
      len      <= len_words;
      byte_cnt <= 2'd0;
      word_cnt <= {(ADDR_W+1){1'b0}};
      word_buf <= 24'h000000;
    end else begin
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= byte_in.s_data;
          2'd1:    word_buf[15:8]  <= byte_in.s_data;
          2'd2:    word_buf[23:16] <= byte_in.s_data;
          default: begin
            wdata <= {byte_in.s_data, word_buf};
            waddr <= base + word_cnt[ADDR_W-1:0];
          end
        endcase
      end
      if (state == WRITE) begin
        word_cnt <= word_cnt_inc;
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running sum of committed words; wdata is the word being written
  // during the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 32'h0000_0000;
    end else if (start_ok) begin
      csum <= 32'h0000_0000;
    end else if (state == WRITE) begin
      csum <= csum + wdata;
    end else begin
      csum <= csum;
    end
  end
`else
  assign csum = 32'h0000_0000;
`endif

endmodule
